imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning instruction-memory depth in 32-bit words (power of two).
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the boot byte on in_data is valid.
REQ-006 The block SHALL have port in_data, input, 8, meaning the boot stream byte.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-008 The block SHALL have port pc, input, 32, meaning the core fetch address (byte address).
REQ-009 The block SHALL have port instr, output, 32, meaning the fetched instruction delivered to the core.
REQ-010 The block SHALL have port core_run, output, 1, meaning the core is released to execute.
REQ-011 The block SHALL have port load_err, output, 1, meaning the boot image was rejected.
REQ-012 The block SHALL have port words_loaded, output, ADDR_W+1, meaning the count of words written so far.

Function
REQ-013 A byte SHALL transfer only on a rising edge where in_valid and in_ready are both 1.
REQ-014 The FSM SHALL have states HDR0, HDR1, DATA, CSUM, RUN and ERR.
REQ-015 in_ready SHALL be 1 in HDR0, HDR1, DATA and CSUM, and 0 in RUN and ERR.
REQ-016 HDR0 SHALL capture count[15:8] and go to HDR1; HDR1 SHALL capture count[7:0].
REQ-017 On the HDR1 transfer, count == 0 or count > DEPTH SHALL go to ERR; otherwise the FSM SHALL go to DATA.
REQ-018 DATA SHALL assemble words big-endian: first byte -> bits 31:24, fourth byte -> bits 7:0.
REQ-019 The word SHALL be written to mem[words_loaded] on the same edge its fourth byte transfers, and words_loaded SHALL increment by 1 on that edge.
REQ-020 When words_loaded reaches count, the FSM SHALL go to CSUM.
REQ-021 A running XOR over all DATA bytes (header excluded) SHALL be kept.
REQ-022 On the CSUM transfer, a byte equal to the running XOR SHALL go to RUN; any other value SHALL go to ERR.
REQ-023 core_run SHALL be 1 exactly while in RUN, and load_err SHALL be 1 exactly while in ERR; both are registered and asserted the cycle after the CSUM/HDR1 edge.
REQ-024 RUN and ERR SHALL be terminal; input bytes are ignored and only rst exits.
REQ-025 instr SHALL be the combinational read mem[pc[ADDR_W+1:2]] when core_run = 1, else 32'h0 (NOP).
REQ-026 pc[1:0] and the pc bits above ADDR_W+1 SHALL be ignored, so addressing wraps modulo DEPTH words.

Reset
REQ-027 rst SHALL asynchronously force state HDR0, words_loaded 0, XOR 0, byte index 0, count 0, core_run 0, load_err 0, in_ready 1 (HDR0), and instr 0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 rst asserted mid-load SHALL abort the load, and the next image SHALL start from HDR0.

Structure
REQ-030 A shared package mips_pkg SHALL hold the loader state enum, DEPTH/ADDR_W defaults and the NOP constant 32'h0.
REQ-031 Storage SHALL be one sub-module imem_ram (one synchronous write port, one asynchronous read port).

Verification
REQ-032 Scenario 1: header 00 02, bytes 20 08 00 05 01 08 40 20, checksum 44 -> core_run=1 next cycle; pc=0 -> instr 0x20080005; pc=4 -> instr 0x01084020; words_loaded=2.
REQ-033 Scenario 2: same image with checksum 45 -> load_err=1, core_run=0, in_ready=0, instr=0 for any pc.
REQ-034 Scenario 3: header 00 00 -> ERR after the second byte; header 01 01 (257) -> ERR after the second byte.
REQ-035 Scenario 4: scenario 1 with in_valid deasserted 3 cycles between bytes -> identical final state, and no byte is accepted while in_valid=0.
REQ-036 Scenario 5: rst pulsed asynchronously after 5 data bytes -> outputs clear without a clock edge; a subsequent scenario 1 load succeeds.
REQ-037 Scenario 6: full 256-word load with word i = i, correct checksum -> pc=0x3FC gives 0x000000FF; pc=0x400 wraps to 0x00000000.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared loader state encoding, memory sizing defaults and NOP constant
package mips_pkg;
  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, RUN, ERR} ld_state_t;
  localparam int DEPTH_DEF = 256;
  localparam int ADDR_W_DEF = 8;
  localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: instruction storage with one synchronous write port and one asynchronous read port
module imem_ram #(
  parameter int DEPTH = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH];
  // contents survive reset so only a fresh load changes them
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a byte-stream boot image into instruction memory, then releases the core
module imem_loader
  import mips_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  input  logic [31:0]     pc,
  output logic [31:0]     instr,
  output logic            core_run,
  output logic            load_err,
  output logic [ADDR_W:0] words_loaded
);
  ld_state_t state, state_n;
  logic [15:0] count;
  logic [15:0] count_hdr;
  logic [1:0] idx;
  logic [23:0] acc;
  logic [7:0] xsum;
  logic [ADDR_W:0] wl_inc;
  logic [31:0] rdata;
  logic fire, last_byte, unused_pc;
  assign in_ready = state inside {HDR0, HDR1, DATA, CSUM};
  assign core_run = state == RUN;
  assign load_err = state == ERR;
  assign fire = in_valid & in_ready;
  assign count_hdr = {count[15:8], in_data};
  assign last_byte = fire && state == DATA && idx == 2'd3;
  assign wl_inc = words_loaded + 1'b1;
  assign instr = core_run ? rdata : NOP;
  assign unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};
  // next state: advance only on an accepted byte; RUN and ERR hold until reset
  always_comb begin
    state_n = state;
    if (fire)
      unique case (state)
        HDR0: state_n = HDR1;
        HDR1: state_n = (count_hdr == 16'd0 || 32'(count_hdr) > 32'(DEPTH)) ? ERR : DATA;
        DATA: state_n = (idx == 2'd3 && 32'(wl_inc) == 32'(count)) ? CSUM : DATA;
        CSUM: state_n = (in_data == xsum) ? RUN : ERR;
        default: state_n = state;
      endcase
  end
  // header capture, big-endian word assembly, running checksum and word counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= HDR0;
      count <= '0;
      idx <= '0;
      acc <= '0;
      xsum <= '0;
      words_loaded <= '0;
    end else begin
      state <= state_n;
      if (fire && state == HDR0) count[15:8] <= in_data;
      if (fire && state == HDR1) count[7:0] <= in_data;
      if (fire && state == DATA) begin
        idx <= idx + 2'd1;
        acc <= {acc[15:0], in_data};
        xsum <= xsum ^ in_data;
      end
      if (last_byte) words_loaded <= wl_inc;
    end
  imem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .we(last_byte),
    .waddr(words_loaded[ADDR_W-1:0]),
    .wdata({acc, in_data}),
    .raddr(pc[ADDR_W+1:2]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized boot images checked against a behavioural image model
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, core_run, load_err;
  logic [7:0] in_data;
  logic [31:0] pc, instr;
  logic [8:0] words_loaded;
  int errors = 0;
  int checks = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] img[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pc(pc), .instr(instr), .core_run(core_run), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b, input int gap);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = $urandom;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  // outputs expected from a finished image, plus reads at directed and random fetch addresses
  task automatic verify(input string tag, input bit run, input bit err, input int words);
    logic [31:0] p;
    chk({tag, ".core_run"}, 32'(core_run), 32'(run));
    chk({tag, ".load_err"}, 32'(load_err), 32'(err));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!run && !err));
    chk({tag, ".words"}, 32'(words_loaded), 32'(words));
    for (int k = 0; k < 4; k++) begin
      p = (k == 0) ? 32'h0 : (k == 1) ? 32'h4 : $urandom;
      pc = p;
      #1 chk({tag, ".instr"}, instr, run ? ref_mem[(p / 4) % 256] : 32'h0);
    end
  endtask

  // send header, words of img and checksum; the model decides outcome from count and XOR
  task automatic load(input string tag, input int cnt, input logic [7:0] csum_flip, input int gmin, input int gmax);
    logic [7:0] x;
    logic [31:0] w;
    x = 8'h0;
    put(8'(cnt >> 8), $urandom_range(gmin, gmax));
    put(8'(cnt), $urandom_range(gmin, gmax));
    if (cnt == 0 || cnt > 256) begin
      verify(tag, 1'b0, 1'b1, 0);
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      w = img[i];
      for (int j = 3; j >= 0; j--) begin
        put(8'(w >> (8 * j)), $urandom_range(gmin, gmax));
        x ^= 8'(w >> (8 * j));
      end
      ref_mem[i] = w;
    end
    put(x ^ csum_flip, 0);
    verify(tag, csum_flip == 8'h0, csum_flip != 8'h0, cnt);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h0;
    pc = 32'h0;
    #12;
    chk("reset.core_run", 32'(core_run), 0);
    chk("reset.load_err", 32'(load_err), 0);
    chk("reset.in_ready", 32'(in_ready), 1);
    chk("reset.words", 32'(words_loaded), 0);
    chk("reset.instr", instr, 0);
    rst = 1'b0;
    // scenario 1, then extra bytes must be ignored
    img = '{32'h20080005, 32'h01084020};
    load("s1", 2, 8'h00, 0, 0);
    pc = 32'h4;
    #1 chk("s1.pc4", instr, 32'h01084020);
    put(8'hAA, 0);
    put(8'h55, 0);
    verify("s1.after", 1'b1, 1'b0, 2);
    // scenario 2: bad checksum
    do_reset();
    load("s2", 2, 8'h01, 0, 0);
    // scenario 3: header boundaries
    do_reset();
    load("s3.zero", 0, 8'h00, 0, 0);
    do_reset();
    load("s3.257", 257, 8'h00, 0, 0);
    // scenario 4: gaps between bytes
    do_reset();
    load("s4", 2, 8'h00, 3, 3);
    // scenario 5: asynchronous reset mid-load
    do_reset();
    put(8'h00, 0);
    put(8'h02, 0);
    for (int i = 0; i < 5; i++) put(8'(img[i / 4] >> (8 * (3 - i % 4))), 0);
    chk("s5.mid_words", 32'(words_loaded), 1);
    chk("s5.mid_ready", 32'(in_ready), 1);
    #2 rst = 1'b1;
    #1;
    chk("s5.rst_words", 32'(words_loaded), 0);
    chk("s5.rst_run", 32'(core_run), 0);
    chk("s5.rst_err", 32'(load_err), 0);
    chk("s5.rst_instr", instr, 0);
    rst = 1'b0;
    load("s5.reload", 2, 8'h00, 0, 1);
    // randomized images with random gaps and occasionally corrupted checksums
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 7);
      img = {};
      for (int i = 0; i < n; i++) img.push_back($urandom);
      do_reset();
      load($sformatf("rnd%0d", r), n, ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 0, 2);
    end
    // scenario 6: full-depth image with wrap-around addressing
    img = {};
    for (int i = 0; i < 256; i++) img.push_back(32'(i));
    do_reset();
    load("s6", 256, 8'h00, 0, 0);
    pc = 32'h3FC;
    #1 chk("s6.pc3fc", instr, 32'h000000FF);
    pc = 32'h400;
    #1 chk("s6.pc400", instr, 32'h00000000);
    pc = 32'hFFFF_F807;
    #1 chk("s6.pc_hi", instr, 32'h00000001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
